// File: rtl/anchor_scheduler_if.sv
// rtl/anchor_scheduler_if.sv - handshake bundle between frame control, window buffer and filter chain
interface anchor_scheduler_if;
  logic        start;
  logic        abort;
  logic        mem_ready;
  logic        filter_final;
  logic        load_req;
  logic        anchor_moving;
  logic [31:0] anchor_x;
  logic [31:0] anchor_y;
  logic        pass_type;
  logic        busy;
  logic        frame_done;
  logic        error;

  modport slave (
    input  start, abort, mem_ready, filter_final,
    output load_req, anchor_moving, anchor_x, anchor_y, pass_type, busy, frame_done, error
  );

  modport master (
    output start, abort, mem_ready, filter_final,
    input  load_req, anchor_moving, anchor_x, anchor_y, pass_type, busy, frame_done, error
  );
endinterface

// File: rtl/anchor_scheduler.sv
// rtl/anchor_scheduler.sv - tile walker: window fill, then blur and edge passes per anchor
// pass_type carries the filter selector (0 blur, 1 edge); all outputs are registered.
module anchor_scheduler #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int STEP_X  = 16,
  parameter int STEP_Y  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_n_rst,
  anchor_scheduler_if.slave     io_sched
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MOVE, S_FILTER, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);
  localparam logic [32:0] STEP_X33  = 33'(STEP_X);
  localparam logic [32:0] STEP_Y33  = 33'(STEP_Y);
  localparam logic [32:0] IMG_W33   = 33'(IMG_W);
  localparam logic [32:0] IMG_H33   = 33'(IMG_H);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_wdog, w_wdog_nxt;
  logic [31:0] r_anchor_x, w_anchor_x_nxt;
  logic [31:0] r_anchor_y, w_anchor_y_nxt;
  logic        r_type, w_type_nxt;
  logic        r_error, w_error_nxt;
  logic        r_load_req, w_load_req_nxt;
  logic        r_moving, w_moving_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_frame_done, w_frame_done_nxt;
  logic        w_timeout;
  logic [32:0] w_x_sum, w_y_sum;
  logic        w_x_more, w_y_more;

  // 33-bit sums so an anchor near 2^32 cannot wrap and look in-range
  assign w_x_sum  = {1'b0, r_anchor_x} + STEP_X33;
  assign w_y_sum  = {1'b0, r_anchor_y} + STEP_Y33;
  assign w_x_more = (w_x_sum < IMG_W33);
  assign w_y_more = (w_y_sum < IMG_H33);

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state      <= S_IDLE;
      r_wdog       <= '0;
      r_anchor_x   <= '0;
      r_anchor_y   <= '0;
      r_type       <= 1'b0;
      r_error      <= 1'b0;
      r_load_req   <= 1'b0;
      r_moving     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wdog       <= w_wdog_nxt;
      r_anchor_x   <= w_anchor_x_nxt;
      r_anchor_y   <= w_anchor_y_nxt;
      r_type       <= w_type_nxt;
      r_error      <= w_error_nxt;
      r_load_req   <= w_load_req_nxt;
      r_moving     <= w_moving_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    if (io_sched.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (io_sched.start) w_state_nxt = S_LOAD;
        S_LOAD: begin
          if (io_sched.mem_ready) begin
            w_state_nxt = S_MOVE;
          end else if (r_wdog == WDOG_LAST) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b1;
          end
        end
        S_MOVE:    w_state_nxt = S_FILTER;
        S_FILTER: begin
          if (io_sched.filter_final) begin
            w_state_nxt = r_type ? S_ADVANCE : S_MOVE;
          end else if (r_wdog == WDOG_LAST) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b1;
          end
        end
        S_ADVANCE: w_state_nxt = (w_x_more || w_y_more) ? S_LOAD : S_DONE;
        S_DONE:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_anchor_x_nxt = r_anchor_x;
    w_anchor_y_nxt = r_anchor_y;
    w_type_nxt     = r_type;
    w_error_nxt    = r_error;
    if (io_sched.abort) begin
      w_anchor_x_nxt = '0;
      w_anchor_y_nxt = '0;
      w_type_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_sched.start) begin
            w_anchor_x_nxt = '0;
            w_anchor_y_nxt = '0;
            w_type_nxt     = 1'b0;
            w_error_nxt    = 1'b0;
          end
        end
        S_FILTER:  if (io_sched.filter_final) w_type_nxt = ~r_type;
        // last tile keeps its origin so the frame's final anchor stays visible
        S_ADVANCE: begin
          if (w_x_more) begin
            w_anchor_x_nxt = w_x_sum[31:0];
          end else if (w_y_more) begin
            w_anchor_x_nxt = '0;
            w_anchor_y_nxt = w_y_sum[31:0];
          end
        end
        default: ;
      endcase
      if (w_timeout) w_error_nxt = 1'b1;
    end
    w_load_req_nxt   = (w_state_nxt == S_LOAD);
    w_moving_nxt     = (w_state_nxt == S_MOVE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_frame_done_nxt = (w_state_nxt == S_DONE);
    if (w_state_nxt != r_state)
      w_wdog_nxt = '0;
    else if (r_state == S_LOAD || r_state == S_FILTER)
      w_wdog_nxt = r_wdog + 32'd1;
    else
      w_wdog_nxt = '0;
  end

  assign io_sched.load_req      = r_load_req;
  assign io_sched.anchor_moving = r_moving;
  assign io_sched.anchor_x      = r_anchor_x;
  assign io_sched.anchor_y      = r_anchor_y;
  assign io_sched.pass_type     = r_type;
  assign io_sched.busy          = r_busy;
  assign io_sched.frame_done    = r_frame_done;
  assign io_sched.error         = r_error;

endmodule

// File: tb/tb_anchor_scheduler.sv
// tb/tb_anchor_scheduler.sv - directed bench for anchor_scheduler (32x32 and 40x32 images)
module tb_anchor_scheduler;

  logic clk;
  logic n_rst;
  int   n_total = 0;
  int   n_pass  = 0;

  anchor_scheduler_if ifa ();
  anchor_scheduler_if ifb ();

  logic m_start_a = 0, m_abort_a = 0, m_mr_a = 0, m_ff_a = 0;
  logic r_mr_a = 0, r_ff_a = 0, m_start_b = 0, r_mr_b = 0, r_ff_b = 0;
  logic en_a = 0;
  int   ff_lim_a = 0;
  int   resp_mt_a = 0;

  assign ifa.start        = m_start_a;
  assign ifa.abort        = m_abort_a;
  assign ifa.mem_ready    = m_mr_a | r_mr_a;
  assign ifa.filter_final = m_ff_a | r_ff_a;
  assign ifb.start        = m_start_b;
  assign ifb.abort        = 1'b0;
  assign ifb.mem_ready    = r_mr_b;
  assign ifb.filter_final = r_ff_b;

  anchor_scheduler #(.IMG_W(32), .IMG_H(32), .STEP_X(16), .STEP_Y(16), .TIMEOUT(64)) u_dut_a (
    .i_clk(clk), .i_n_rst(n_rst), .io_sched(ifa)
  );
  anchor_scheduler #(.IMG_W(40), .IMG_H(32), .STEP_X(16), .STEP_Y(16), .TIMEOUT(64)) u_dut_b (
    .i_clk(clk), .i_n_rst(n_rst), .io_sched(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // window-buffer / filter models: mem_ready 3 cycles into load_req, filter_final 5 after a pulse
  initial begin : resp_a
    int lc, fc;
    bit fp;
    lc = 0; fc = 0; fp = 0;
    forever begin
      @(negedge clk);
      r_mr_a = 1'b0;
      r_ff_a = 1'b0;
      if (ifa.load_req && en_a) begin
        lc++;
        if (lc == 3) r_mr_a = 1'b1;
      end else lc = 0;
      if (ifa.anchor_moving) begin
        resp_mt_a++;
        fp = en_a && (resp_mt_a <= ff_lim_a);
        fc = 0;
      end else if (fp) begin
        fc++;
        if (fc == 5) begin r_ff_a = 1'b1; fp = 0; end
      end
      if (!ifa.busy) fp = 0;
    end
  end

  initial begin : resp_b
    int lc, fc;
    bit fp;
    lc = 0; fc = 0; fp = 0;
    forever begin
      @(negedge clk);
      r_mr_b = 1'b0;
      r_ff_b = 1'b0;
      if (ifb.load_req) begin
        lc++;
        if (lc == 3) r_mr_b = 1'b1;
      end else lc = 0;
      if (ifb.anchor_moving) begin fp = 1; fc = 0; end
      else if (fp) begin
        fc++;
        if (fc == 5) begin r_ff_b = 1'b1; fp = 0; end
      end
    end
  end

  logic [31:0] qx_a[$], qy_a[$], qx_b[$], qy_b[$];
  logic        qt_a[$];
  int          n_load_a = 0, n_done_a = 0, n_done_b = 0;

  initial begin : mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.anchor_moving) begin
        qx_a.push_back(ifa.anchor_x);
        qy_a.push_back(ifa.anchor_y);
        qt_a.push_back(ifa.pass_type);
      end
      if (ifa.load_req && !prev) n_load_a++;
      prev = ifa.load_req;
      if (ifa.frame_done) n_done_a++;
      if (ifb.anchor_moving) begin
        qx_b.push_back(ifb.anchor_x);
        qy_b.push_back(ifb.anchor_y);
      end
      if (ifb.frame_done) n_done_b++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    m_start_a = 1'b1;
    @(negedge clk);
    m_start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int base, input string tag);
    int c;
    c = 0;
    while (n_done_a == base && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_wait"}, 64'(c < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  int exp_x4 [8] = '{0, 0, 16, 16, 0, 0, 16, 16};
  int exp_y4 [8] = '{0, 0, 0, 0, 16, 16, 16, 16};
  int exp_xb [6] = '{0, 0, 16, 16, 32, 32};

  initial begin : main
    int qb, lb, db, n, k, c, x3;
    bit ok;
    logic prev;

    // reset values
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", ifa.busy, 0);
    check("rst_load_req", ifa.load_req, 0);
    check("rst_anchor_x", ifa.anchor_x, 0);
    check("rst_error", ifa.error, 0);
    check("rst_frame_done", ifa.frame_done, 0);
    n_rst = 1'b1;

    // full 32x32 frame
    en_a = 1'b1;
    ff_lim_a = resp_mt_a + 1000;
    qb = qx_a.size(); lb = n_load_a; db = n_done_a;
    pulse_start_a();
    check("f1_busy_after_start", ifa.busy, 1);
    check("f1_load_req_after_start", ifa.load_req, 1);
    wait_done_a(db, "f1");
    check("f1_pulses", qx_a.size() - qb, 8);
    for (int i = 0; i < 8; i++) begin
      if (qb + i < qx_a.size()) begin
        check($sformatf("f1_x%0d", i), qx_a[qb + i], exp_x4[i]);
        check($sformatf("f1_y%0d", i), qy_a[qb + i], exp_y4[i]);
        check($sformatf("f1_t%0d", i), qt_a[qb + i], i % 2);
      end
    end
    check("f1_loads", n_load_a - lb, 4);
    check("f1_done", n_done_a - db, 1);
    check("f1_busy_end", ifa.busy, 0);
    check("f1_final_x", ifa.anchor_x, 16);
    check("f1_final_y", ifa.anchor_y, 16);

    // 40-pixel width: partial last tile column
    qb = qx_b.size(); db = n_done_b;
    @(negedge clk);
    m_start_b = 1'b1;
    @(negedge clk);
    m_start_b = 1'b0;
    c = 0;
    while (n_done_b == db && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("w40_done_wait", 64'(c < 3000), 1);
    repeat (5) @(negedge clk);
    check("w40_pulses", qx_b.size() - qb, 12);
    check("w40_done", n_done_b - db, 1);
    for (int i = 0; i < 12; i++) begin
      if (qb + i < qx_b.size()) begin
        check($sformatf("w40_x%0d", i), qx_b[qb + i], exp_xb[i % 6]);
        check($sformatf("w40_y%0d", i), qy_b[qb + i], (i < 6) ? 0 : 16);
      end
    end
    check("w40_busy_end", ifb.busy, 0);

    // filter_final during MOVE is ignored
    en_a = 1'b0;
    qb = qx_a.size();
    pulse_start_a();
    check("mv_load_req", ifa.load_req, 1);
    m_mr_a = 1'b1;
    m_ff_a = 1'b1;
    @(negedge clk);
    check("mv_moving", ifa.anchor_moving, 1);
    m_mr_a = 1'b0;
    m_ff_a = 1'b0;
    repeat (4) @(negedge clk);
    check("mv_type_still_blur", ifa.pass_type, 0);
    check("mv_no_second_pulse", qx_a.size() - qb, 1);
    check("mv_still_busy", ifa.busy, 1);
    m_ff_a = 1'b1;
    @(negedge clk);
    m_ff_a = 1'b0;
    check("mv_second_pulse", ifa.anchor_moving, 1);
    check("mv_type_edge", ifa.pass_type, 1);
    m_abort_a = 1'b1;
    @(negedge clk);
    m_abort_a = 1'b0;
    check("mv_abort_busy", ifa.busy, 0);
    check("mv_abort_type", ifa.pass_type, 0);

    // watchdog timeout in FILTER after the second pulse
    en_a = 1'b1;
    ff_lim_a = resp_mt_a + 1;
    qb = qx_a.size();
    pulse_start_a();
    n = 0;
    for (int i = 0; i < 500 && n < 2; i++) begin
      @(negedge clk);
      if (ifa.anchor_moving) n++;
    end
    check("to_second_pulse_seen", n, 2);
    c = 0;
    while (!ifa.error && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("to_cycles", c, 65);
    check("to_error", ifa.error, 1);
    check("to_busy", ifa.busy, 0);
    check("to_load_req", ifa.load_req, 0);
    check("to_pulses", qx_a.size() - qb, 2);
    ff_lim_a = resp_mt_a + 1000;
    db = n_done_a; qb = qx_a.size();
    pulse_start_a();
    check("to_restart_error_clr", ifa.error, 0);
    check("to_restart_busy", ifa.busy, 1);
    check("to_restart_x", ifa.anchor_x, 0);
    check("to_restart_y", ifa.anchor_y, 0);
    wait_done_a(db, "to_restart");
    check("to_restart_pulses", qx_a.size() - qb, 8);
    check("to_restart_error_end", ifa.error, 0);

    // start while busy ignored; abort beats same-cycle filter_final in tile 2
    ff_lim_a = resp_mt_a + 2;
    db = n_done_a;
    pulse_start_a();
    n = 0; k = 0; ok = 0; x3 = -1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      m_start_a = (n == 1 && k == 2);
      if (ifa.anchor_moving) begin
        n++;
        k = 0;
        if (n == 3) begin x3 = int'(ifa.anchor_x); ok = 1; end
      end else k++;
    end
    m_start_a = 1'b0;
    check("ab_third_pulse_seen", ok, 1);
    check("ab_third_pulse_x", x3, 16);
    repeat (5) @(negedge clk);
    m_ff_a = 1'b1;
    m_abort_a = 1'b1;
    @(negedge clk);
    m_ff_a = 1'b0;
    m_abort_a = 1'b0;
    check("ab_busy", ifa.busy, 0);
    check("ab_moving", ifa.anchor_moving, 0);
    check("ab_x", ifa.anchor_x, 0);
    check("ab_type", ifa.pass_type, 0);
    repeat (5) @(negedge clk);
    check("ab_no_frame_done", n_done_a - db, 0);
    check("ab_still_idle", ifa.busy, 0);

    // async reset during LOAD of tile 3
    ff_lim_a = resp_mt_a + 1000;
    pulse_start_a();
    n = 1; prev = 1'b1; ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (ifa.load_req && !prev) begin
        n++;
        if (n == 3) ok = 1;
      end
      prev = ifa.load_req;
    end
    check("rs_tile3_load_seen", ok, 1);
    check("rs_tile3_y", ifa.anchor_y, 16);
    n_rst = 1'b0;
    #1;
    check("rs_busy", ifa.busy, 0);
    check("rs_load_req", ifa.load_req, 0);
    check("rs_y", ifa.anchor_y, 0);
    check("rs_moving", ifa.anchor_moving, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    qb = qx_a.size(); lb = n_load_a; db = n_done_a;
    pulse_start_a();
    wait_done_a(db, "rs_clean");
    check("rs_clean_pulses", qx_a.size() - qb, 8);
    check("rs_clean_loads", n_load_a - lb, 4);
    check("rs_clean_done", n_done_a - db, 1);
    check("rs_clean_busy", ifa.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
